// File: rtl/clint_pkg.sv
// Shared CLINT definitions: register offsets, reset constants and the offset decoder.
package clint_pkg;

  localparam logic [31:0] ClintBase          = 32'h0200_0000;
  localparam logic [15:0] ClintMsipOfs       = 16'h0000;
  localparam logic [15:0] ClintMtimecmpLoOfs = 16'h4000;
  localparam logic [15:0] ClintMtimecmpHiOfs = 16'h4004;
  localparam logic [15:0] ClintMtimeLoOfs    = 16'hBFF8;
  localparam logic [15:0] ClintMtimeHiOfs    = 16'hBFFC;
  localparam logic [63:0] ClintMtimecmpRst   = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    RegNone,
    RegMsip,
    RegCmpLo,
    RegCmpHi,
    RegTimeLo,
    RegTimeHi
  } clint_reg_e;

  function automatic clint_reg_e clint_decode(input logic [15:0] ofs);
    case (ofs)
      ClintMsipOfs:       return RegMsip;
      ClintMtimecmpLoOfs: return RegCmpLo;
      ClintMtimecmpHiOfs: return RegCmpHi;
      ClintMtimeLoOfs:    return RegTimeLo;
      ClintMtimeHiOfs:    return RegTimeHi;
      default:            return RegNone;
    endcase
  endfunction

endpackage

// File: rtl/clint_if.sv
// Core data-bus port of the CLINT: single-beat request with a one-cycle ack pulse.
interface clint_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              req_i;
  logic              we_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       wdata_i;
  logic              ack_o;
  logic [31:0]       rdata_o;
  logic              err_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  ack_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output ack_o, rdata_o, err_o
  );
endinterface

// File: rtl/clint_timer.sv
// Prescaled 64-bit mtime counter, mtimecmp register and the registered timer interrupt.
module clint_timer
  import clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        time_wr_lo_i,
  input  logic        time_wr_hi_i,
  input  logic        cmp_wr_lo_i,
  input  logic        cmp_wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] mtime_o,
  output logic [63:0] mtimecmp_o,
  output logic        irq_timer_o
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CntW-1:0] presc_q, presc_d;
  logic [63:0]     mtime_q, mtime_d;
  logic [63:0]     cmp_q, cmp_d;
  logic            irq_q;
  logic            tick;

  assign tick    = (presc_q == CntW'(TICK_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + 1'b1;

  // A bus write to either half replaces that half and suppresses the tick.
  always_comb begin
    mtime_d = mtime_q;
    if (time_wr_lo_i)      mtime_d = {mtime_q[63:32], wdata_i};
    else if (time_wr_hi_i) mtime_d = {wdata_i, mtime_q[31:0]};
    else if (tick)         mtime_d = mtime_q + 64'd1;

    cmp_d = cmp_q;
    if (cmp_wr_lo_i)      cmp_d = {cmp_q[63:32], wdata_i};
    else if (cmp_wr_hi_i) cmp_d = {wdata_i, cmp_q[31:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      mtime_q <= '0;
      cmp_q   <= ClintMtimecmpRst;
      irq_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      irq_q   <= (mtime_q >= cmp_q);
    end
  end

  assign mtime_o     = mtime_q;
  assign mtimecmp_o  = cmp_q;
  assign irq_timer_o = irq_q;

endmodule

// File: rtl/clint.sv
// Core-local interruptor: msip, mtime, mtimecmp behind a single-beat bus port.
// Define CLINT_HI_LATCH_EN for torn-free 64-bit reads via hi-half shadows latched on lo reads.
module clint
  import clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic    clk,
  input  logic    rst,
  clint_if.slave  bus,
  output logic    irq_software_o,
  output logic    irq_timer_o
);

  logic [ADDR_W+15:0] addr_ext;
  logic [15:0]        ofs;
  clint_reg_e         reg_sel;
  logic               accept, wr, rd;
  logic               ack_q, err_q, msip_q, msip_d;
  logic [31:0]        rdata_q, rdata_mux;
  logic [63:0]        mtime, mtimecmp;

  // Offsets beyond the 16-bit map never alias onto a register.
  assign addr_ext = {16'b0, bus.addr_i};
  assign ofs      = addr_ext[15:0] & 16'hFFFC;
  assign reg_sel  = (addr_ext[ADDR_W+15:16] == '0) ? clint_decode(ofs) : RegNone;

  assign accept = bus.req_i && !ack_q;
  assign wr     = accept && bus.we_i;
  assign rd     = accept && !bus.we_i;
  assign msip_d = (wr && reg_sel == RegMsip) ? bus.wdata_i[0] : msip_q;

  clint_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk          (clk),
    .rst          (rst),
    .time_wr_lo_i (wr && reg_sel == RegTimeLo),
    .time_wr_hi_i (wr && reg_sel == RegTimeHi),
    .cmp_wr_lo_i  (wr && reg_sel == RegCmpLo),
    .cmp_wr_hi_i  (wr && reg_sel == RegCmpHi),
    .wdata_i      (bus.wdata_i),
    .mtime_o      (mtime),
    .mtimecmp_o   (mtimecmp),
    .irq_timer_o  (irq_timer_o)
  );

`ifdef CLINT_HI_LATCH_EN
  logic [31:0] time_hi_sh_q, cmp_hi_sh_q;
`endif

  always_comb begin
    rdata_mux = 32'h0;
    case (reg_sel)
      RegMsip:   rdata_mux = {31'b0, msip_q};
      RegCmpLo:  rdata_mux = mtimecmp[31:0];
      RegTimeLo: rdata_mux = mtime[31:0];
`ifdef CLINT_HI_LATCH_EN
      RegCmpHi:  rdata_mux = cmp_hi_sh_q;
      RegTimeHi: rdata_mux = time_hi_sh_q;
`else
      RegCmpHi:  rdata_mux = mtimecmp[63:32];
      RegTimeHi: rdata_mux = mtime[63:32];
`endif
      default:   rdata_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      msip_q  <= 1'b0;
`ifdef CLINT_HI_LATCH_EN
      time_hi_sh_q <= 32'h0;
      cmp_hi_sh_q  <= 32'h0;
`endif
    end else begin
      ack_q   <= accept;
      err_q   <= accept && (reg_sel == RegNone);
      rdata_q <= rd ? rdata_mux : 32'h0;
      msip_q  <= msip_d;
`ifdef CLINT_HI_LATCH_EN
      if (rd && reg_sel == RegTimeLo) time_hi_sh_q <= mtime[63:32];
      if (rd && reg_sel == RegCmpLo)  cmp_hi_sh_q  <= mtimecmp[63:32];
`endif
    end
  end

  assign bus.ack_o      = ack_q;
  assign bus.err_o      = err_q;
  assign bus.rdata_o    = rdata_q;
  assign irq_software_o = msip_q;

endmodule
